// File: rtl/branch_predict_resolve_unit.sv
// Branch resolve unit with a bimodal direction predictor.
// Fetch looks up a 2-bit counter table; execute resolves branches, trains the table and keeps statistics.
module branch_predict_resolve_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int IMM_WIDTH   = 13,
  parameter int BHT_ENTRIES = 64,
  parameter int CTR_INIT    = 1,
  parameter int PC_INC      = 4,
  parameter int STAT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  lkValid,
  input  logic [ADDR_WIDTH-1:0] lkPC,
  output logic                  predValid,
  output logic                  predTaken,
  input  logic                  resValid,
  input  logic [ADDR_WIDTH-1:0] resPC,
  input  logic [2:0]            brCode,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic [IMM_WIDTH-1:0]  constant,
  input  logic                  predTakenIn,
  output logic                  outValid,
  output logic [ADDR_WIDTH-1:0] pcOut,
  output logic                  brTaken,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] brCount,
  output logic [STAT_WIDTH-1:0] missCount
);

  // Both sides are valid-only: there is no ready/backpressure. A request is
  // accepted on every rising edge where its valid is high and rst is low, and
  // its result appears, registered, exactly one cycle later.

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [1:0] CTR_RST = 2'(CTR_INIT);

  logic [1:0] bht [BHT_ENTRIES];

  logic [IDX_W-1:0]      lkIdx;
  logic [IDX_W-1:0]      resIdx;
  logic                  isLegal;
  logic                  isTaken;
  logic [ADDR_WIDTH-1:0] disp;
  logic [ADDR_WIDTH-1:0] nextPc;
  logic                  isMiss;
  logic                  unusedPcBits;

  assign lkIdx  = lkPC[IDX_W+1:2];
  assign resIdx = resPC[IDX_W+1:2];
  assign unusedPcBits = ^{lkPC[ADDR_WIDTH-1:IDX_W+2], lkPC[1:0],
                          resPC[ADDR_WIDTH-1:IDX_W+2], resPC[1:0]};

  always_comb begin
    isLegal = 1'b1;
    isTaken = 1'b0;
    case (brCode)
      3'b000:  isTaken = (rs1 == rs2);
      3'b001:  isTaken = (rs1 != rs2);
      3'b100:  isTaken = ($signed(rs1) <  $signed(rs2));
      3'b101:  isTaken = ($signed(rs1) >= $signed(rs2));
      3'b110:  isTaken = (rs1 <  rs2);
      3'b111:  isTaken = (rs1 >= rs2);
      default: isLegal = 1'b0;
    endcase
  end

  // Displacement is a two's-complement byte offset; the add wraps modulo 2^ADDR_WIDTH.
  assign disp   = {{(ADDR_WIDTH-IMM_WIDTH){constant[IMM_WIDTH-1]}}, constant};
  assign nextPc = resPC + (isTaken ? disp : ADDR_WIDTH'(PC_INC));
  assign isMiss = isTaken ^ predTakenIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      predValid  <= 1'b0;
      predTaken  <= 1'b0;
      outValid   <= 1'b0;
      pcOut      <= '0;
      brTaken    <= 1'b0;
      mispredict <= 1'b0;
      brCount    <= '0;
      missCount  <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_RST;
    end else begin
      predValid <= lkValid & ~flush;
      // Lookup reads the old counter value, so same-cycle training is seen next cycle.
      if (lkValid && !flush) predTaken <= bht[lkIdx][1];

      outValid   <= resValid;
      mispredict <= resValid & isMiss;
      if (resValid) begin
        pcOut   <= nextPc;
        brTaken <= isTaken;
      end

      if (resValid && isLegal) begin
        if (isTaken) begin
          if (bht[resIdx] != 2'd3) bht[resIdx] <= bht[resIdx] + 2'd1;
        end else begin
          if (bht[resIdx] != 2'd0) bht[resIdx] <= bht[resIdx] - 2'd1;
        end
        if (brCount != '1) brCount <= brCount + STAT_WIDTH'(1);
        if (isMiss && (missCount != '1)) missCount <= missCount + STAT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench for branch_predict_resolve_unit: hand-computed expectations for
// lookup, resolve, training saturation, read-before-write, wrap, illegal codes and reset.
module tb_branch_predict_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        lkValid;
  logic [31:0] lkPC;
  logic        predValid;
  logic        predTaken;
  logic        resValid;
  logic [31:0] resPC;
  logic [2:0]  brCode;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [12:0] constant;
  logic        predTakenIn;
  logic        outValid;
  logic [31:0] pcOut;
  logic        brTaken;
  logic        mispredict;
  logic [31:0] brCount;
  logic [31:0] missCount;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  branch_predict_resolve_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lkValid(lkValid), .lkPC(lkPC), .predValid(predValid), .predTaken(predTaken),
    .resValid(resValid), .resPC(resPC), .brCode(brCode), .rs1(rs1), .rs2(rs2),
    .constant(constant), .predTakenIn(predTakenIn),
    .outValid(outValid), .pcOut(pcOut), .brTaken(brTaken), .mispredict(mispredict),
    .brCount(brCount), .missCount(missCount)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; lkValid = 1'b0; resValid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lkValid = 1'b1; lkPC = pc;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [12:0] imm, input logic pin);
    resValid = 1'b1; resPC = pc; brCode = code; rs1 = a; rs2 = b;
    constant = imm; predTakenIn = pin;
  endtask

  task automatic check_res(input string tag, input logic [31:0] pc, input logic tk,
                           input logic mp, input int bc, input int mc);
    check_val({tag, ".outValid"}, 64'(outValid), 64'd1);
    check_val({tag, ".pcOut"}, 64'(pcOut), 64'(pc));
    check_val({tag, ".brTaken"}, 64'(brTaken), 64'(tk));
    check_val({tag, ".mispredict"}, 64'(mispredict), 64'(mp));
    check_val({tag, ".brCount"}, 64'(brCount), 64'(bc));
    check_val({tag, ".missCount"}, 64'(missCount), 64'(mc));
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
    idle(); lookup(pc); step();
    check_val({tag, ".predValid"}, 64'(predValid), 64'd1);
    check_val({tag, ".predTaken"}, 64'(predTaken), 64'(exp));
  endtask

  initial begin
    rst = 1'b1; idle();
    lkPC = '0; resPC = '0; brCode = '0; rs1 = '0; rs2 = '0; constant = '0; predTakenIn = 1'b0;
    #1;
    // Requests presented during reset must be dropped.
    lookup(32'h100); resolve(32'h100, 3'b000, 1, 1, 13'd8, 1'b0);
    step(); step();
    rst = 1'b0; idle(); step();
    check_val("rst.predValid", 64'(predValid), 64'd0);
    check_val("rst.predTaken", 64'(predTaken), 64'd0);
    check_val("rst.outValid", 64'(outValid), 64'd0);
    check_val("rst.pcOut", 64'(pcOut), 64'd0);
    check_val("rst.brTaken", 64'(brTaken), 64'd0);
    check_val("rst.mispredict", 64'(mispredict), 64'd0);
    check_val("rst.brCount", 64'(brCount), 64'd0);
    check_val("rst.missCount", 64'(missCount), 64'd0);

    // Initial counters are weakly not-taken; flush squashes the next result.
    check_pred("lk0", 32'h100, 1'b0);
    idle(); lookup(32'h100); flush = 1'b1; step();
    check_val("flush.predValid", 64'(predValid), 64'd0);

    // BEQ taken with negative displacement (idx 0: 1 -> 2).
    idle(); resolve(32'h100, 3'b000, 5, 5, 13'h1FF8, 1'b0); step();
    check_res("beq", 32'hF8, 1'b1, 1'b1, 1, 1);
    idle(); step();
    check_val("hold.outValid", 64'(outValid), 64'd0);
    check_val("hold.mispredict", 64'(mispredict), 64'd0);
    check_val("hold.pcOut", 64'(pcOut), 64'hF8);
    check_val("hold.brTaken", 64'(brTaken), 64'd1);

    // Signed vs unsigned on 0xFFFFFFFF vs 1 (idx 0: 2 -> 3 -> 2).
    idle(); resolve(32'h200, 3'b100, 32'hFFFF_FFFF, 1, 13'd16, 1'b1); step();
    check_res("blt", 32'h210, 1'b1, 1'b0, 2, 1);
    idle(); resolve(32'h200, 3'b110, 32'hFFFF_FFFF, 1, 13'd16, 1'b1); step();
    check_res("bltu", 32'h204, 1'b0, 1'b1, 3, 2);

    // Saturate up at 0x40 (idx 16), then down.
    for (int i = 0; i < 2; i++) begin
      idle(); resolve(32'h40, 3'b101, 3, 3, 13'd8, 1'b1); step();
    end
    check_res("bge", 32'h48, 1'b1, 1'b0, 5, 2);
    check_pred("sat3", 32'h40, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(); resolve(32'h40, 3'b001, 7, 7, 13'd8, 1'b0); step();
    end
    check_res("bne_nt", 32'h44, 1'b0, 1'b0, 9, 2);
    check_pred("sat0", 32'h40, 1'b0);
    // One taken from 0 must give 1, still predicted not-taken (no wrap from 0 to 3).
    idle(); resolve(32'h40, 3'b101, 3, 3, 13'd8, 1'b1); step();
    check_pred("after0", 32'h40, 1'b0);

    // Same-cycle lookup and training at 0x80 (idx 32): read-before-write.
    idle(); lookup(32'h80); resolve(32'h80, 3'b111, 5, 2, 13'd8, 1'b0); step();
    check_val("rbw.predTaken", 64'(predTaken), 64'd0);
    check_res("bgeu", 32'h88, 1'b1, 1'b1, 11, 3);
    check_pred("rbw.next", 32'h80, 1'b1);

    // Target wrap.
    idle(); resolve(32'hFFFF_FFFC, 3'b001, 1, 2, 13'd8, 1'b1); step();
    check_res("wrap", 32'h4, 1'b1, 1'b0, 12, 3);

    // Illegal code: not taken, not counted, no training (idx 0 stays 2).
    idle(); resolve(32'h300, 3'b010, 9, 9, 13'd8, 1'b1); step();
    check_res("illegal", 32'h304, 1'b0, 1'b1, 12, 3);
    check_pred("illegal.notrain", 32'h300, 1'b1);

    // Reset the cycle after a resolve discards the following result and restores counters.
    idle(); resolve(32'h80, 3'b000, 1, 1, 13'd8, 1'b0); step();
    rst = 1'b1; step();
    rst = 1'b0; idle(); step();
    check_val("midrst.outValid", 64'(outValid), 64'd0);
    check_val("midrst.brCount", 64'(brCount), 64'd0);
    check_val("midrst.missCount", 64'(missCount), 64'd0);
    check_val("midrst.pcOut", 64'(pcOut), 64'd0);
    check_pred("midrst.ctr80", 32'h80, 1'b0);
    check_pred("midrst.ctr0", 32'h0, 1'b0);

    idle(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
